// File: rtl/combat_pkg.sv
// -----------------------------------------------------------------------------
// combat_pkg
// Shared types and constants for the per-frame combat stage.
//   attack_state_t : per-player attack phase (IDLE, WINDUP, ACTIVE, RECOVER)
//   game_state_t   : match state (FIGHT, KO)
//   KEY_*          : USB keycodes for attack and guard keys
//   WIN_*          : Winner output encodings
//   box_t          : half-open rectangle [x0,x1) x [y0,y1) in 11-bit pixels
// Helpers build body/hit boxes and test strict rectangle intersection.
// -----------------------------------------------------------------------------
package combat_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } attack_state_t;

    typedef enum logic {
        FIGHT = 1'b0,
        KO    = 1'b1
    } game_state_t;

    localparam logic [7:0] KEY_P1_ATTACK = 8'h09;  // F
    localparam logic [7:0] KEY_P2_ATTACK = 8'h12;  // O
    localparam logic [7:0] KEY_P1_GUARD  = 8'h16;  // S
    localparam logic [7:0] KEY_P2_GUARD  = 8'h0e;  // K

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // 11 bits holds a 10-bit position plus the largest box width and reach
    // without wrapping.
    localparam int COORD_W = 11;
    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } box_t;

    function automatic logic key_held(input logic [7:0] k0, input logic [7:0] k1,
                                      input logic [7:0] k2, input logic [7:0] k3,
                                      input logic [7:0] key);
        return (k0 == key) || (k1 == key) || (k2 == key) || (k3 == key);
    endfunction

    function automatic box_t make_body(input coord_t x, input coord_t y,
                                       input coord_t w, input coord_t h);
        box_t b;
        b.x0 = x;
        b.x1 = x + w;
        b.y0 = y;
        b.y1 = y + h;
        return b;
    endfunction

    // Hitbox extends REACH pixels out from the front edge. A left-facing
    // hitbox near the screen edge clamps at 0 instead of wrapping around.
    function automatic box_t make_hitbox(input coord_t x, input coord_t y,
                                         input coord_t w, input coord_t h,
                                         input coord_t reach, input logic faces_right);
        box_t b;
        if (faces_right) begin
            b.x0 = x + w;
            b.x1 = x + w + reach;
        end else begin
            b.x1 = x;
            b.x0 = (x >= reach) ? (x - reach) : '0;
        end
        b.y0 = y;
        b.y1 = y + h;
        return b;
    endfunction

    function automatic logic boxes_overlap(input box_t a, input box_t b);
        return (a.x0 < b.x1) && (b.x0 < a.x1) && (a.y0 < b.y1) && (b.y0 < a.y1);
    endfunction

    function automatic logic [7:0] sat_sub(input logic [7:0] h, input logic [7:0] d);
        return (h > d) ? (h - d) : 8'd0;
    endfunction

endpackage

// File: rtl/combat_engine_attack_fsm.sv
// -----------------------------------------------------------------------------
// attack_fsm
// One player's attack sequencer: IDLE -> WINDUP -> ACTIVE -> RECOVER -> IDLE.
// Ports:
//   frame_clk, Reset : frame clock, async active-high reset
//   key_present      : attack key is in one of the keycode slots this frame
//   fight_en         : match still running; low in KO
//   hit_set          : this player's attack landed on this edge
//   state            : registered attack phase
//   trigger          : rising edge of key presence, accepted only in FIGHT
//   hit_landed       : the current attack has already landed a hit
// Interface is frame-synchronous with no handshake: every input is sampled
// on each frame_clk edge and every output is valid for the whole frame.
// -----------------------------------------------------------------------------
module attack_fsm
    import combat_pkg::*;
#(
    parameter int WINDUP_FRAMES  = 4,
    parameter int ACTIVE_FRAMES  = 3,
    parameter int RECOVER_FRAMES = 8,
    parameter int CNT_W          = 8
) (
    input  logic          frame_clk,
    input  logic          Reset,
    input  logic          key_present,
    input  logic          fight_en,
    input  logic          hit_set,
    output attack_state_t state,
    output logic          trigger,
    output logic          hit_landed
);

    localparam logic [CNT_W-1:0] WINDUP_LOAD  = CNT_W'(WINDUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD  = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] RECOVER_LOAD = CNT_W'(RECOVER_FRAMES - 1);

    attack_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_prev_q, key_prev_d;
    logic             hit_landed_q, hit_landed_d;

    // Only a fresh press starts an attack; holding the key never re-fires.
    assign trigger = key_present && !key_prev_q && fight_en;

    always_comb begin
        key_prev_d   = key_present;
        state_d      = state_q;
        cnt_d        = cnt_q;
        hit_landed_d = hit_landed_q || hit_set;

        if (state_q == IDLE) begin
            // Triggers arriving outside IDLE are simply dropped.
            if (trigger) begin
                state_d      = WINDUP;
                cnt_d        = WINDUP_LOAD;
                hit_landed_d = 1'b0;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!fight_en) begin
            // After KO the current phase runs out, then the player rests.
            state_d = IDLE;
        end else begin
            case (state_q)
                WINDUP: begin
                    state_d = ACTIVE;
                    cnt_d   = ACTIVE_LOAD;
                end
                ACTIVE: begin
                    state_d = RECOVER;
                    cnt_d   = RECOVER_LOAD;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            key_prev_q   <= 1'b0;
            hit_landed_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_prev_q   <= key_prev_d;
            hit_landed_q <= hit_landed_d;
        end
    end

    assign state      = state_q;
    assign hit_landed = hit_landed_q;

endmodule

// File: rtl/combat_engine.sv
// -----------------------------------------------------------------------------
// combat_engine
// Per-frame combat stage: two attack sequencers, hitbox-vs-body overlap,
// saturating health with post-hit invulnerability, and a latched KO result.
// Ports:
//   frame_clk, Reset            : frame clock, async active-high reset
//   keycode_0..keycode_3        : current USB keycodes (0x00 = empty slot)
//   Player1X/Y, Player2X/Y      : body top-left positions
//   P1_Health, P2_Health        : current health
//   P1_Attacking, P2_Attacking  : player's attack phase is not IDLE
//   P1_Hit, P2_Hit              : one-frame pulse, that player took damage
//   Game_Over                   : KO latched
//   Winner                      : 00 none, 01 P1, 10 P2, 11 draw
//   dbg_state                   : {game, p2_trig, p1_trig, p2_state, p1_state}
// Build option: define COMBAT_BLOCK_EN to halve damage taken by a defender
// holding their guard key (P1 0x16, P2 0x0e) while facing the attacker.
// Interface is frame-synchronous with no handshake: inputs are sampled on
// each frame_clk edge and outputs hold for the whole following frame.
// -----------------------------------------------------------------------------
module combat_engine
    import combat_pkg::*;
#(
    parameter int HEALTH_MAX     = 100,
    parameter int DAMAGE         = 10,
    parameter int WINDUP_FRAMES  = 4,
    parameter int ACTIVE_FRAMES  = 3,
    parameter int RECOVER_FRAMES = 8,
    parameter int REACH          = 40,
    parameter int INVULN_FRAMES  = 16,
    parameter int P1_W           = 120,
    parameter int P1_H           = 180,
    parameter int P2_W           = 140,
    parameter int P2_H           = 240
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [9:0] Player1X,
    input  logic [9:0] Player1Y,
    input  logic [9:0] Player2X,
    input  logic [9:0] Player2Y,
    output logic [7:0] P1_Health,
    output logic [7:0] P2_Health,
    output logic       P1_Attacking,
    output logic       P2_Attacking,
    output logic       P1_Hit,
    output logic       P2_Hit,
    output logic       Game_Over,
    output logic [1:0] Winner,
    output logic [6:0] dbg_state
);

    localparam logic [7:0] HEALTH_INIT = 8'(HEALTH_MAX);
    localparam logic [7:0] DMG_FULL    = 8'(DAMAGE);
    localparam logic [7:0] INV_LOAD    = 8'(INVULN_FRAMES);
    localparam coord_t     P1_W_C      = coord_t'(P1_W);
    localparam coord_t     P1_H_C      = coord_t'(P1_H);
    localparam coord_t     P2_W_C      = coord_t'(P2_W);
    localparam coord_t     P2_H_C      = coord_t'(P2_H);
    localparam coord_t     REACH_C     = coord_t'(REACH);

    game_state_t   game_q, game_d;
    logic [1:0]    winner_q, winner_d;
    logic [7:0]    p1_health_q, p1_health_d;
    logic [7:0]    p2_health_q, p2_health_d;
    logic [7:0]    p1_invuln_q, p1_invuln_d;
    logic [7:0]    p2_invuln_q, p2_invuln_d;
    logic          p1_hit_q, p1_hit_d;
    logic          p2_hit_q, p2_hit_d;

    logic          fight;
    logic          p1_atk_key, p2_atk_key;
    attack_state_t p1_state, p2_state;
    logic          p1_trig, p2_trig;
    logic          p1_hit_landed, p2_hit_landed;
    logic          p1_lands, p2_lands;   // pN's attack connects this edge
    logic [7:0]    dmg_to_p1, dmg_to_p2;

    coord_t        p1_x, p1_y, p2_x, p2_y;
    logic          p1_faces_right;
    box_t          p1_body, p2_body, p1_hitbox, p2_hitbox;
    logic          p1_reach, p2_reach;

    assign fight      = (game_q == FIGHT);
    assign p1_atk_key = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_ATTACK);
    assign p2_atk_key = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_ATTACK);

    attack_fsm #(
        .WINDUP_FRAMES (WINDUP_FRAMES),
        .ACTIVE_FRAMES (ACTIVE_FRAMES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_p1_fsm (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .key_present(p1_atk_key),
        .fight_en   (fight),
        .hit_set    (p1_lands),
        .state      (p1_state),
        .trigger    (p1_trig),
        .hit_landed (p1_hit_landed)
    );

    attack_fsm #(
        .WINDUP_FRAMES (WINDUP_FRAMES),
        .ACTIVE_FRAMES (ACTIVE_FRAMES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_p2_fsm (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .key_present(p2_atk_key),
        .fight_en   (fight),
        .hit_set    (p2_lands),
        .state      (p2_state),
        .trigger    (p2_trig),
        .hit_landed (p2_hit_landed)
    );

    // Geometry uses the live positions from the movement stage, so the
    // hitbox follows a player who moves during ACTIVE.
    assign p1_x = {1'b0, Player1X};
    assign p1_y = {1'b0, Player1Y};
    assign p2_x = {1'b0, Player2X};
    assign p2_y = {1'b0, Player2Y};

    // The players always face each other; a tie in X counts as P1 on the left.
    assign p1_faces_right = (Player1X <= Player2X);

    assign p1_body   = make_body(p1_x, p1_y, P1_W_C, P1_H_C);
    assign p2_body   = make_body(p2_x, p2_y, P2_W_C, P2_H_C);
    assign p1_hitbox = make_hitbox(p1_x, p1_y, P1_W_C, P1_H_C, REACH_C, p1_faces_right);
    assign p2_hitbox = make_hitbox(p2_x, p2_y, P2_W_C, P2_H_C, REACH_C, !p1_faces_right);
    assign p1_reach  = boxes_overlap(p1_hitbox, p2_body);
    assign p2_reach  = boxes_overlap(p2_hitbox, p1_body);

    assign p1_lands = fight && (p1_state == ACTIVE) && p1_reach && !p1_hit_landed
                      && (p2_invuln_q == 8'd0);
    assign p2_lands = fight && (p2_state == ACTIVE) && p2_reach && !p2_hit_landed
                      && (p1_invuln_q == 8'd0);

`ifdef COMBAT_BLOCK_EN
    localparam logic [7:0] DMG_HALF = 8'(DAMAGE >> 1);
    // Because the players always face each other, a held guard key is
    // always pointed at the attacker.
    assign dmg_to_p1 = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P1_GUARD)
                       ? DMG_HALF : DMG_FULL;
    assign dmg_to_p2 = key_held(keycode_0, keycode_1, keycode_2, keycode_3, KEY_P2_GUARD)
                       ? DMG_HALF : DMG_FULL;
`else
    assign dmg_to_p1 = DMG_FULL;
    assign dmg_to_p2 = DMG_FULL;
`endif

    always_comb begin
        p1_health_d = p1_health_q;
        p2_health_d = p2_health_q;
        p1_invuln_d = (p1_invuln_q != 8'd0) ? (p1_invuln_q - 8'd1) : 8'd0;
        p2_invuln_d = (p2_invuln_q != 8'd0) ? (p2_invuln_q - 8'd1) : 8'd0;
        p1_hit_d    = p2_lands;
        p2_hit_d    = p1_lands;
        game_d      = game_q;
        winner_d    = winner_q;

        // Both directions are evaluated independently so simultaneous hits
        // apply on the same edge.
        if (p1_lands) begin
            p2_health_d = sat_sub(p2_health_q, dmg_to_p2);
            p2_invuln_d = INV_LOAD;
        end
        if (p2_lands) begin
            p1_health_d = sat_sub(p1_health_q, dmg_to_p1);
            p1_invuln_d = INV_LOAD;
        end

        // KO looks at the registered health, so it follows one edge after
        // a health register reaches 0 and can still catch a draw.
        if (fight && (p1_health_q == 8'd0 || p2_health_q == 8'd0)) begin
            game_d = KO;
            if (p1_health_q == 8'd0 && p2_health_q == 8'd0) begin
                winner_d = WIN_DRAW;
            end else if (p2_health_q == 8'd0) begin
                winner_d = WIN_P1;
            end else begin
                winner_d = WIN_P2;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            game_q      <= FIGHT;
            winner_q    <= WIN_NONE;
            p1_health_q <= HEALTH_INIT;
            p2_health_q <= HEALTH_INIT;
            p1_invuln_q <= 8'd0;
            p2_invuln_q <= 8'd0;
            p1_hit_q    <= 1'b0;
            p2_hit_q    <= 1'b0;
        end else begin
            game_q      <= game_d;
            winner_q    <= winner_d;
            p1_health_q <= p1_health_d;
            p2_health_q <= p2_health_d;
            p1_invuln_q <= p1_invuln_d;
            p2_invuln_q <= p2_invuln_d;
            p1_hit_q    <= p1_hit_d;
            p2_hit_q    <= p2_hit_d;
        end
    end

    assign P1_Health    = p1_health_q;
    assign P2_Health    = p2_health_q;
    assign P1_Attacking = (p1_state != IDLE);
    assign P2_Attacking = (p2_state != IDLE);
    assign P1_Hit       = p1_hit_q;
    assign P2_Hit       = p2_hit_q;
    assign Game_Over    = (game_q == KO);
    assign Winner       = winner_q;
    assign dbg_state    = {game_q, p2_trig, p1_trig, p2_state, p1_state};

endmodule

// File: tb/tb_combat_engine.sv
// -----------------------------------------------------------------------------
// tb_combat_engine
// Self-checking bench for combat_engine. A reference model tracks each
// attack as "frames since the press" and derives phase, reach and damage
// from plain integer geometry; directed tasks add fixed expected values.
// Define COMBAT_BLOCK_EN to build the guard-key variant.
// -----------------------------------------------------------------------------
module tb_combat_engine;

    localparam int W_F   = 4;
    localparam int A_F   = 3;
    localparam int R_F   = 8;
    localparam int INV   = 16;
    localparam int DMG   = 10;
    localparam int HMAX  = 100;
    localparam int REACH = 40;
    localparam int P1W = 120, P1H = 180, P2W = 140, P2H = 240;

    logic       frame_clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] keycode_0 = 8'h00, keycode_1 = 8'h00, keycode_2 = 8'h00, keycode_3 = 8'h00;
    logic [9:0] Player1X = 10'd40, Player1Y = 10'd220, Player2X = 10'd480, Player2Y = 10'd160;
    logic [7:0] P1_Health, P2_Health;
    logic       P1_Attacking, P2_Attacking, P1_Hit, P2_Hit, Game_Over;
    logic [1:0] Winner;
    logic [6:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    combat_engine dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycode_0   (keycode_0),
        .keycode_1   (keycode_1),
        .keycode_2   (keycode_2),
        .keycode_3   (keycode_3),
        .Player1X    (Player1X),
        .Player1Y    (Player1Y),
        .Player2X    (Player2X),
        .Player2Y    (Player2Y),
        .P1_Health   (P1_Health),
        .P2_Health   (P2_Health),
        .P1_Attacking(P1_Attacking),
        .P2_Attacking(P2_Attacking),
        .P1_Hit      (P1_Hit),
        .P2_Hit      (P2_Hit),
        .Game_Over   (Game_Over),
        .Winner      (Winner),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 frame_clk = ~frame_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // m_age[i] = frames elapsed since player i's attack started, -1 = idle.
    int         m_age[2]    = '{-1, -1};
    bit         m_prev[2]   = '{0, 0};
    bit         m_landed[2] = '{0, 0};
    int         m_inv[2]    = '{0, 0};
    int         m_health[2] = '{HMAX, HMAX};
    bit         m_hit[2]    = '{0, 0};
    bit         m_ko        = 0;
    logic [1:0] m_winner    = 2'b00;

    function automatic bit key_in(input logic [7:0] k);
        return keycode_0 == k || keycode_1 == k || keycode_2 == k || keycode_3 == k;
    endfunction

    function automatic bit in_active(input int a);
        return a >= W_F && a < W_F + A_F;
    endfunction

    function automatic bit phase_end(input int a);
        return a == W_F || a == W_F + A_F || a == W_F + A_F + R_F;
    endfunction

    function automatic int max0(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    task automatic model_step();
        bit fight;
        int p1x, p1y, p2x, p2y, h0, h1;
        bit p1r;
        bit ov[2], lands[2], pres[2], trig;
        int dmg[2];
        fight = !m_ko;
        p1x = int'(Player1X); p1y = int'(Player1Y);
        p2x = int'(Player2X); p2y = int'(Player2Y);
        p1r = (p1x <= p2x);
        if (p1r) begin h0 = p1x + P1W; h1 = h0 + REACH; end
        else     begin h1 = p1x; h0 = max0(p1x - REACH); end
        ov[0] = (h0 < p2x + P2W) && (p2x < h1) && (p1y < p2y + P2H) && (p2y < p1y + P1H);
        if (!p1r) begin h0 = p2x + P2W; h1 = h0 + REACH; end
        else      begin h1 = p2x; h0 = max0(p2x - REACH); end
        ov[1] = (h0 < p1x + P1W) && (p1x < h1) && (p2y < p1y + P1H) && (p1y < p2y + P2H);
        pres[0] = key_in(8'h09);
        pres[1] = key_in(8'h12);
        dmg[0] = DMG;
        dmg[1] = DMG;
`ifdef COMBAT_BLOCK_EN
        if (key_in(8'h0e)) dmg[0] = DMG / 2;
        if (key_in(8'h16)) dmg[1] = DMG / 2;
`endif
        for (int i = 0; i < 2; i++)
            lands[i] = fight && in_active(m_age[i]) && ov[i] && !m_landed[i] && m_inv[1-i] == 0;
        if (fight && (m_health[0] == 0 || m_health[1] == 0)) begin
            m_ko = 1;
            if (m_health[0] == 0 && m_health[1] == 0) m_winner = 2'b11;
            else if (m_health[1] == 0)                m_winner = 2'b01;
            else                                      m_winner = 2'b10;
        end
        for (int i = 0; i < 2; i++) begin
            if (lands[i]) begin
                m_health[1-i] = max0(m_health[1-i] - dmg[i]);
                m_inv[1-i] = INV;
            end else if (m_inv[1-i] > 0) begin
                m_inv[1-i] = m_inv[1-i] - 1;
            end
            m_hit[1-i] = lands[i];
        end
        for (int i = 0; i < 2; i++) begin
            trig = pres[i] && !m_prev[i] && fight;
            if (m_age[i] < 0) begin
                if (trig) begin m_age[i] = 0; m_landed[i] = 0; end
            end else begin
                if (lands[i]) m_landed[i] = 1;
                m_age[i] = m_age[i] + 1;
                if (m_age[i] == W_F + A_F + R_F || (!fight && phase_end(m_age[i])))
                    m_age[i] = -1;
            end
            m_prev[i] = pres[i];
        end
    endtask

    always @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            m_age = '{-1, -1}; m_prev = '{0, 0}; m_landed = '{0, 0};
            m_inv = '{0, 0}; m_health = '{HMAX, HMAX}; m_hit = '{0, 0};
            m_ko = 0; m_winner = 2'b00;
        end else begin
            model_step();
        end
    end

    logic [22:0] dut_vec, mdl_vec;
    assign dut_vec = {P1_Health, P2_Health, P1_Attacking, P2_Attacking, P1_Hit, P2_Hit,
                      Game_Over, Winner};
    assign mdl_vec = {8'(m_health[0]), 8'(m_health[1]), m_age[0] >= 0, m_age[1] >= 0,
                      m_hit[0], m_hit[1], m_ko, m_winner};

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    task automatic set_keys(input logic [7:0] k0, input logic [7:0] k1,
                            input logic [7:0] k2, input logic [7:0] k3);
        keycode_0 = k0; keycode_1 = k1; keycode_2 = k2; keycode_3 = k3;
    endtask

    task automatic set_pos(input int x1, input int y1, input int x2, input int y2);
        Player1X = 10'(x1); Player1Y = 10'(y1); Player2X = 10'(x2); Player2Y = 10'(y2);
    endtask

    function automatic logic [7:0] pick_key();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 8'h00;
            5:             return 8'h09;
            6:             return 8'h12;
            7:             return 8'h16;
            8:             return 8'h0e;
            default:       return 8'($urandom_range(1, 255));
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        int hits;
        set_keys(0, 0, 0, 0);
        set_pos(40, 220, 480, 160);
        do_reset();
        #1;
        n_cmp++;
        if ({P1_Health, P2_Health} !== {8'd100, 8'd100}) begin
            n_bad++; $display("FAIL reset_health: got %0d/%0d want 100/100", P1_Health, P2_Health);
        end
        n_cmp++;
        if ({Game_Over, Winner, P1_Attacking, P2_Attacking, P1_Hit, P2_Hit} !== 7'b0) begin
            n_bad++; $display("FAIL reset_flags: go=%b win=%b att=%b%b hit=%b%b want all 0",
                              Game_Over, Winner, P1_Attacking, P2_Attacking, P1_Hit, P2_Hit);
        end
        n_cmp++;
        if (dbg_state !== 7'd0) begin
            n_bad++; $display("FAIL reset_dbg_state: got %b want 0", dbg_state);
        end
        // Out-of-reach press: hitbox 160..200 against body 480..620.
        @(negedge frame_clk);
        set_keys(8'h09, 0, 0, 0);
        hits = 0;
        for (int k = 0; k < 18; k++) begin
            @(negedge frame_clk);
            hits += P2_Hit;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL reset_miss_model k=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
        end
        n_cmp++;
        if (P2_Health !== 8'd100 || hits != 0) begin
            n_bad++; $display("FAIL reset_miss: P2_Health=%0d hits=%0d want 100 and 0", P2_Health, hits);
        end
        set_keys(0, 0, 0, 0);
    endtask

    // Leaves F released and P1 idle at the negedge after edge n+15.
    task automatic test_single_hit();
        int hits;
        set_pos(40, 220, 150, 160);
        do_reset();
        set_keys(8'h09, 0, 0, 0);      // first present at edge n
        hits = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge frame_clk);      // after edge n+k
            hits += P2_Hit;
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL single_model k=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
            if (k == 0) begin
                n_cmp++;
                if (P1_Attacking !== 1'b1) begin
                    n_bad++; $display("FAIL single_attacking_start: got %b want 1", P1_Attacking);
                end
            end
            if (k == 4) begin
                n_cmp++;
                if (P2_Health !== 8'd100) begin
                    n_bad++; $display("FAIL single_early: P2_Health=%0d want 100", P2_Health);
                end
            end
            if (k == 5) begin
                n_cmp++;
                if (P2_Health !== 8'd90 || P2_Hit !== 1'b1) begin
                    n_bad++; $display("FAIL single_hit: P2_Health=%0d P2_Hit=%b want 90 1", P2_Health, P2_Hit);
                end
            end
            if (k == 14 || k == 15) begin
                n_cmp++;
                if (P1_Attacking !== (k == 14)) begin
                    n_bad++; $display("FAIL single_idle k=%0d: P1_Attacking=%b want %b", k, P1_Attacking, k == 14);
                end
            end
            if (k == 9) set_keys(0, 0, 0, 0);
        end
        n_cmp++;
        if (hits != 1 || P2_Health !== 8'd90) begin
            n_bad++; $display("FAIL single_count: hits=%0d P2_Health=%0d want 1 90", hits, P2_Health);
        end
    endtask

    // Continues from test_single_hit: invulnerability ends after edge n+21,
    // so the first ACTIVE frame (edge n+21) is blocked and edge n+22 lands.
    task automatic test_invuln();
        set_keys(8'h09, 0, 0, 0);      // present at edge m = n+16
        for (int j = 0; j < 17; j++) begin
            @(negedge frame_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL invuln_model j=%0d: got %h want %h", j, dut_vec, mdl_vec);
            end
            if (j == 5) begin
                n_cmp++;
                if (P2_Health !== 8'd90 || P2_Hit !== 1'b0) begin
                    n_bad++; $display("FAIL invuln_blocked: P2_Health=%0d P2_Hit=%b want 90 0", P2_Health, P2_Hit);
                end
            end
            if (j == 6) begin
                n_cmp++;
                if (P2_Health !== 8'd80 || P2_Hit !== 1'b1) begin
                    n_bad++; $display("FAIL invuln_expired: P2_Health=%0d P2_Hit=%b want 80 1", P2_Health, P2_Hit);
                end
            end
            if (j == 2) set_keys(0, 0, 0, 0);
        end
    endtask

    task automatic test_simultaneous();
        set_pos(40, 220, 150, 160);
        set_keys(0, 0, 0, 0);
        do_reset();
        set_keys(8'h12, 8'h00, 8'h09, 8'h00);
        for (int k = 0; k < 8; k++) begin
            @(negedge frame_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL simul_model k=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
            if (k == 5) begin
                n_cmp++;
                if ({P1_Health, P2_Health, P1_Hit, P2_Hit} !== {8'd90, 8'd90, 2'b11}) begin
                    n_bad++; $display("FAIL simul_hit: health=%0d/%0d hit=%b%b want 90/90 11",
                                      P1_Health, P2_Health, P1_Hit, P2_Hit);
                end
            end
        end
        set_keys(0, 0, 0, 0);
    endtask

    // Strict-edge and left-facing clamp cases, all P1 attacking.
    task automatic test_edges();
        int cx1[3] = '{40, 40, 30};
        int cx2[3] = '{200, 199, 10};
        int cexp[3] = '{100, 90, 90};
        for (int c = 0; c < 3; c++) begin
            set_keys(0, 0, 0, 0);
            set_pos(cx1[c], 200, cx2[c], 200);
            do_reset();
            set_keys(8'h09, 0, 0, 0);
            for (int k = 0; k < 8; k++) begin
                @(negedge frame_clk);
                n_cmp++;
                if (dut_vec !== mdl_vec) begin
                    n_bad++; $display("FAIL edge_model c=%0d k=%0d: got %h want %h", c, k, dut_vec, mdl_vec);
                end
            end
            n_cmp++;
            if (P2_Health !== 8'(cexp[c])) begin
                n_bad++; $display("FAIL edge_case c=%0d: P2_Health=%0d want %0d", c, P2_Health, cexp[c]);
            end
        end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_ko();
        int hz, gz;
        set_pos(40, 220, 150, 160);
        set_keys(0, 0, 0, 0);
        do_reset();
        hz = -1; gz = -1;
        for (int f = 0; f < 240; f++) begin
            if (f > 0) begin
                @(negedge frame_clk);
                n_cmp++;
                if (dut_vec !== mdl_vec) begin
                    n_bad++; $display("FAIL ko_model f=%0d: got %h want %h", f, dut_vec, mdl_vec);
                end
                if (hz < 0 && P2_Health == 8'd0) hz = f;
                if (gz < 0 && Game_Over === 1'b1) gz = f;
                if (f == 203) begin
                    n_cmp++;
                    if (P2_Health !== 8'd10) begin
                        n_bad++; $display("FAIL ko_before: P2_Health=%0d want 10", P2_Health);
                    end
                end
            end
            set_keys((f % 22 == 0) ? 8'h09 : 8'h00, 0, 0, 0);
        end
        n_cmp++;
        if (hz != 204 || gz != hz + 1) begin
            n_bad++; $display("FAIL ko_timing: health0 at %0d, game_over at %0d want 204 and 205", hz, gz);
        end
        n_cmp++;
        if ({P1_Health, P2_Health, Game_Over, Winner, P1_Attacking} !== {8'd100, 8'd0, 1'b1, 2'b01, 1'b0}) begin
            n_bad++; $display("FAIL ko_final: health=%0d/%0d go=%b win=%b att=%b want 100/0 1 01 0",
                              P1_Health, P2_Health, Game_Over, Winner, P1_Attacking);
        end
        // Asynchronous reset in the middle of a frame during KO.
        @(negedge frame_clk);
        #2 Reset = 1'b1;
        #1;
        n_cmp++;
        if ({P1_Health, P2_Health, Game_Over, Winner, P1_Attacking, P2_Attacking, P1_Hit, P2_Hit}
            !== {8'd100, 8'd100, 7'b0}) begin
            n_bad++; $display("FAIL ko_async_reset: health=%0d/%0d go=%b win=%b want 100/100 0 00",
                              P1_Health, P2_Health, Game_Over, Winner);
        end
        @(negedge frame_clk);
        Reset = 1'b0;
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_block();
        int exp_h;
`ifdef COMBAT_BLOCK_EN
        exp_h = 95;
`else
        exp_h = 90;
`endif
        set_pos(40, 220, 150, 160);
        set_keys(0, 0, 0, 0);
        do_reset();
        set_keys(8'h09, 8'h0e, 0, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge frame_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL block_model k=%0d: got %h want %h", k, dut_vec, mdl_vec);
            end
            if (k == 5) begin
                n_cmp++;
                if (P2_Health !== 8'(exp_h) || P2_Hit !== 1'b1) begin
                    n_bad++; $display("FAIL block_damage: P2_Health=%0d P2_Hit=%b want %0d 1", P2_Health, P2_Hit, exp_h);
                end
            end
        end
        set_keys(0, 0, 0, 0);
    endtask

    task automatic test_random();
        int x1, x2;
        set_keys(0, 0, 0, 0);
        do_reset();
        for (int f = 0; f < 800; f++) begin
            @(negedge frame_clk);
            n_cmp++;
            if (dut_vec !== mdl_vec) begin
                n_bad++; $display("FAIL random_model f=%0d: got %h want %h", f, dut_vec, mdl_vec);
            end
            if (f % 12 == 0) begin
                x1 = $urandom_range(0, 500);
                x2 = x1 + $urandom_range(0, 320) - 160;
                if (x2 < 0) x2 = 0;
                set_pos(x1, $urandom_range(100, 300), x2, $urandom_range(100, 300));
            end
            set_keys(pick_key(), pick_key(), pick_key(), pick_key());
            if (f % 200 == 199) begin
                #2 Reset = 1'b1;       // spans the next rising edge
                #4 Reset = 1'b0;
            end
        end
        set_keys(0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln();
        test_simultaneous();
        test_edges();
        test_ko();
        test_block();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
